riscv_mc_core: RTL

//  Multi-cycle RV32I core: wraps the existing datapath and control unit with a sequencing FSM.

---
 rtl/riscv_mc_core_pkg.sv | 48 ++++
 rtl/riscv_mc_seq.sv | 121 ++++++++++++
 rtl/riscv_mc_core.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mc_core_pkg.sv
// rtl/riscv_mc_core_pkg.sv - shared types and constants for the multi-cycle RV32I core
package riscv_mc_core_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_FETCH_WAIT,
      ST_EXEC,
      ST_MEM,
      ST_MEM_WAIT,
      ST_COMMIT,
      ST_TRAP
   } mc_state_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } aluop_t;

   typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JAL, PC_JALR} pcsel_t;
   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wbsel_t;

   localparam logic [3:0] BYTEEN_WORD = 4'hF;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // funct3/funct7[5] to ALU operation; alt only selects SUB for register ops
   function automatic aluop_t alu_decode(input logic [2:0] f3, input logic alt, input logic is_reg);
      case (f3)
         3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/riscv_mc_seq.sv
// rtl/riscv_mc_seq.sv - sequencing FSM, wait counter and trap logic of the multi-cycle core
module riscv_mc_seq
   import riscv_mc_core_pkg::*;
#(
   parameter int MAX_WAIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bus_gnt,
   input  logic bus_rvalid,
   input  logic is_mem,
   input  logic pc_misaligned,
   input  logic next_pc_misaligned,
   output logic bus_req,
   output logic err_o,
   output logic fetch_issue,
   output logic mem_issue,
   output logic ir_load,
   output logic mdr_load,
   output logic commit
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

   mc_state_t     state;
   logic [CW-1:0] wait_cnt;
   logic [CW-1:0] wait_inc;
   logic          timed_out;

   // saturating increment of the wait counter and the timeout it would reach
   always_comb begin
      wait_inc  = (wait_cnt == '1) ? wait_cnt : wait_cnt + CW'(1);
      timed_out = (wait_inc >= WAIT_LIMIT);
   end

   // the first FETCH cycle after reset has bus_req low; it checks alignment and raises the request
   assign fetch_issue = ((state == ST_FETCH) && !bus_req && !pc_misaligned) ||
                        ((state == ST_COMMIT) && !next_pc_misaligned);
   assign mem_issue   = (state == ST_EXEC) && is_mem;
   assign ir_load     = (state == ST_FETCH_WAIT) && bus_rvalid;
   assign mdr_load    = (state == ST_MEM_WAIT) && bus_rvalid;
   assign commit      = (state == ST_COMMIT);

   // state sequencing with registered request/error outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_FETCH;
         bus_req  <= 1'b0;
         err_o    <= 1'b0;
         wait_cnt <= '0;
      end else begin
         case (state)
            ST_FETCH, ST_MEM: begin
               if (!bus_req) begin
                  if (pc_misaligned) begin
                     state <= ST_TRAP;
                     err_o <= 1'b1;
                  end else begin
                     bus_req <= 1'b1;
                  end
               end else if (bus_gnt && bus_rvalid) begin
                  state   <= ST_TRAP;
                  bus_req <= 1'b0;
                  err_o   <= 1'b1;
               end else if (bus_gnt) begin
                  state    <= (state == ST_FETCH) ? ST_FETCH_WAIT : ST_MEM_WAIT;
                  bus_req  <= 1'b0;
                  wait_cnt <= '0;
               end else if (timed_out) begin
                  state   <= ST_TRAP;
                  bus_req <= 1'b0;
                  err_o   <= 1'b1;
               end else begin
                  wait_cnt <= wait_inc;
               end
            end
            ST_FETCH_WAIT, ST_MEM_WAIT: begin
               if (bus_rvalid) begin
                  state    <= (state == ST_FETCH_WAIT) ? ST_EXEC : ST_COMMIT;
                  wait_cnt <= '0;
               end else if (timed_out) begin
                  state <= ST_TRAP;
                  err_o <= 1'b1;
               end else begin
                  wait_cnt <= wait_inc;
               end
            end
            ST_EXEC: begin
               wait_cnt <= '0;
               if (is_mem) begin
                  state   <= ST_MEM;
                  bus_req <= 1'b1;
               end else begin
                  state <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               wait_cnt <= '0;
               if (next_pc_misaligned) begin
                  state <= ST_TRAP;
                  err_o <= 1'b1;
               end else begin
                  state   <= ST_FETCH;
                  bus_req <= 1'b1;
               end
            end
            ST_TRAP: begin
               bus_req <= 1'b0;
               err_o   <= 1'b1;
            end
            default: begin
               state   <= ST_TRAP;
               bus_req <= 1'b0;
               err_o   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/riscv_mc_core.sv
// rtl/riscv_mc_core.sv - multi-cycle RV32I core with a shared variable-latency memory port
module riscv_mc_core
   import riscv_mc_core_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter int               MAX_WAIT  = 16,
   parameter int               CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 bus_req,
   output logic                 bus_we,
   output logic [WIDTH-1:0]     bus_addr,
   output logic [WIDTH-1:0]     bus_wdata,
   output logic [3:0]           bus_byteen,
   input  logic                 bus_gnt,
   input  logic                 bus_rvalid,
   input  logic [WIDTH-1:0]     bus_rdata,
   output logic [WIDTH-1:0]     pc_o,
   output logic                 err_o,
   output logic [CNT_WIDTH-1:0] instret_o
);

   logic [WIDTH-1:0]     pc, ir, mdr;
   logic [CNT_WIDTH-1:0] instret;
   logic [WIDTH-1:0]     rf [0:31];

   logic fetch_issue, mem_issue, ir_load, mdr_load, commit;

   logic [6:0] opcode;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] f3;
   logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [WIDTH-1:0] rs1_val, rs2_val;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign f3     = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign imm_i  = {{(WIDTH-12){ir[31]}}, ir[31:20]};
   assign imm_s  = {{(WIDTH-12){ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b  = {{(WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u  = {ir[31:12], 12'b0};
   assign imm_j  = {{(WIDTH-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

   assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
   assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

   logic             ctl_reg_write, ctl_src_imm, ctl_a_pc, ctl_a_zero, is_load, is_store;
   aluop_t           ctl_alu_op;
   pcsel_t           ctl_pc_sel;
   wbsel_t           ctl_wb_sel;
   logic [WIDTH-1:0] imm;

   // control unit: decodes IR into datapath controls; unknown opcodes act as NOP
   always_comb begin
      ctl_reg_write = 1'b0;
      ctl_src_imm   = 1'b0;
      ctl_a_pc      = 1'b0;
      ctl_a_zero    = 1'b0;
      is_load       = 1'b0;
      is_store      = 1'b0;
      ctl_alu_op    = ALU_ADD;
      ctl_pc_sel    = PC_PLUS4;
      ctl_wb_sel    = WB_ALU;
      imm           = imm_i;
      case (opcode)
         OP_LUI:    begin ctl_reg_write = 1'b1; ctl_a_zero = 1'b1; ctl_src_imm = 1'b1; imm = imm_u; end
         OP_AUIPC:  begin ctl_reg_write = 1'b1; ctl_a_pc = 1'b1; ctl_src_imm = 1'b1; imm = imm_u; end
         OP_JAL:    begin ctl_reg_write = 1'b1; ctl_pc_sel = PC_JAL; ctl_wb_sel = WB_PC4; end
         OP_JALR:   begin ctl_reg_write = 1'b1; ctl_src_imm = 1'b1; ctl_pc_sel = PC_JALR; ctl_wb_sel = WB_PC4; end
         OP_BRANCH: ctl_pc_sel = PC_BRANCH;
         OP_LOAD:   begin ctl_reg_write = 1'b1; ctl_src_imm = 1'b1; is_load = 1'b1; ctl_wb_sel = WB_MEM; end
         OP_STORE:  begin ctl_src_imm = 1'b1; is_store = 1'b1; imm = imm_s; end
         OP_IMM:    begin ctl_reg_write = 1'b1; ctl_src_imm = 1'b1; ctl_alu_op = alu_decode(f3, ir[30], 1'b0); end
         OP_REG:    begin ctl_reg_write = 1'b1; ctl_alu_op = alu_decode(f3, ir[30], 1'b1); end
         default:   ;
      endcase
   end

   logic [WIDTH-1:0] alu_a, alu_b, alu_res;
   logic [4:0]       shamt;

   // ALU, combinational on IR and the register file
   always_comb begin
      alu_a = ctl_a_zero ? '0 : (ctl_a_pc ? pc : rs1_val);
      alu_b = ctl_src_imm ? imm : rs2_val;
      shamt = alu_b[4:0];
      case (ctl_alu_op)
         ALU_SUB:  alu_res = alu_a - alu_b;
         ALU_SLL:  alu_res = alu_a << shamt;
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
         ALU_XOR:  alu_res = alu_a ^ alu_b;
         ALU_SRL:  alu_res = alu_a >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(alu_a) >>> shamt);
         ALU_OR:   alu_res = alu_a | alu_b;
         ALU_AND:  alu_res = alu_a & alu_b;
         default:  alu_res = alu_a + alu_b;
      endcase
   end

   logic             br_taken;
   logic [WIDTH-1:0] pc_plus4, next_pc;

   // branch compare and next-PC selection
   always_comb begin
      case (f3)
         3'b000:  br_taken = (rs1_val == rs2_val);
         3'b001:  br_taken = (rs1_val != rs2_val);
         3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
         3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  br_taken = (rs1_val < rs2_val);
         3'b111:  br_taken = (rs1_val >= rs2_val);
         default: br_taken = 1'b0;
      endcase
      pc_plus4 = pc + WIDTH'(4);
      case (ctl_pc_sel)
         PC_BRANCH: next_pc = br_taken ? pc + imm_b : pc_plus4;
         PC_JAL:    next_pc = pc + imm_j;
         PC_JALR:   next_pc = {alu_res[WIDTH-1:1], 1'b0};
         default:   next_pc = pc_plus4;
      endcase
   end

   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [WIDTH-1:0] ld_data, wb_data, st_wdata;
   logic [3:0]       st_byteen;

   // load extraction, writeback mux and store lane alignment
   always_comb begin
      ld_byte = mdr[{alu_res[1:0], 3'b000} +: 8];
      ld_half = mdr[{alu_res[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
         3'b100:  ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
         3'b101:  ld_data = {{(WIDTH-16){1'b0}}, ld_half};
         default: ld_data = mdr;
      endcase
      case (ctl_wb_sel)
         WB_MEM:  wb_data = ld_data;
         WB_PC4:  wb_data = pc_plus4;
         default: wb_data = alu_res;
      endcase
      case (f3)
         3'b000: begin
            st_byteen = 4'b0001 << alu_res[1:0];
            st_wdata  = rs2_val << {alu_res[1:0], 3'b000};
         end
         3'b001: begin
            st_byteen = alu_res[1] ? 4'b1100 : 4'b0011;
            st_wdata  = rs2_val << {alu_res[1], 4'b0000};
         end
         default: begin
            st_byteen = BYTEEN_WORD;
            st_wdata  = rs2_val;
         end
      endcase
   end

   riscv_mc_seq #(.MAX_WAIT(MAX_WAIT)) u_seq (
      .clk                (clk),
      .rst_n              (rst_n),
      .bus_gnt            (bus_gnt),
      .bus_rvalid         (bus_rvalid),
      .is_mem             (is_load | is_store),
      .pc_misaligned      (pc[1:0] != 2'b00),
      .next_pc_misaligned (next_pc[1:0] != 2'b00),
      .bus_req            (bus_req),
      .err_o              (err_o),
      .fetch_issue        (fetch_issue),
      .mem_issue          (mem_issue),
      .ir_load            (ir_load),
      .mdr_load           (mdr_load),
      .commit             (commit)
   );

   // architectural state: PC and instret only move in COMMIT
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         ir      <= '0;
         mdr     <= '0;
         instret <= '0;
      end else begin
         if (ir_load) ir <= bus_rdata;
         if (mdr_load && is_load) mdr <= bus_rdata;
         if (commit) begin
            pc      <= next_pc;
            instret <= instret + CNT_WIDTH'(1);
         end
      end
   end

   // register file write, gated by the commit strobe
   always_ff @(posedge clk) begin
      if (rst_n && commit && ctl_reg_write && (rd != 5'd0)) rf[rd] <= wb_data;
   end

   // bus address/data/strobes, captured when a request is issued and held until the next one
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         bus_byteen <= 4'h0;
      end else if (fetch_issue) begin
         bus_we     <= 1'b0;
         bus_addr   <= commit ? next_pc : pc;
         bus_wdata  <= '0;
         bus_byteen <= BYTEEN_WORD;
      end else if (mem_issue) begin
         bus_we     <= is_store;
         bus_addr   <= alu_res;
         bus_wdata  <= is_store ? st_wdata : '0;
         bus_byteen <= is_store ? st_byteen : BYTEEN_WORD;
      end
   end

   assign pc_o      = pc;
   assign instret_o = instret;

endmodule
